// File: rtl/rv32_pkg.sv
// Shared RV32 fetch definitions: NOP encoding, fetch FSM states,
// default reset vector and the fetch address legality helper.
package rv32_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FS_BOOT,
    FS_RUN,
    FS_FAULT
  } fetch_state_e;

  function automatic logic addr_bad(
    input logic [31:0] a,
    input logic [31:0] lim
  );
    return (a[1:0] != 2'b00) || (a >= lim);
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if_id_pipe_reg.sv
// IF/ID pipeline register: flush wins over load, otherwise hold.
// Flush clears valid and the instruction but keeps the pc fields.
module if_id_pipe_reg
  import rv32_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] instr_o
);

  logic        valid_q;
  logic [31:0] pc_q;
  logic [31:0] pc4_q;
  logic [31:0] instr_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      pc4_q   <= '0;
      instr_q <= NOP;
    end else if (flush_i) begin
      valid_q <= 1'b0;
      instr_q <= NOP;
    end else if (load_i) begin
      valid_q <= 1'b1;
      pc_q    <= pc_i;
      pc4_q   <= pc_i + 32'd4;
      instr_q <= instr_i;
    end
  end

  assign valid_o    = valid_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc4_q;
  assign instr_o    = instr_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Single-issue instruction fetch: pc register, BOOT/RUN/FAULT FSM,
// redirect/stall handling and delivered-instruction counter.
module instruction_fetch_unit
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          IMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic [31:0] if_id_instr,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] LIMIT = 32'(IMEM_WORDS) << 2;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  fetch_count_q, fetch_count_d;
  logic [31:0]  pc_plus4;
  logic         load, flush;
  logic         run_redir, run_fetch, in_fault;

  assign pc_plus4  = pc_q + 32'd4;
  assign run_redir = (state_q == FS_RUN) && redirect_valid;
  assign run_fetch = (state_q == FS_RUN) && !redirect_valid
                  && !stall && !addr_bad(pc_q, LIMIT);
  assign in_fault  = (state_q == FS_FAULT);

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= FS_BOOT;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FS_BOOT: state_d = FS_RUN;
      FS_RUN: begin
        if (redirect_valid) begin
          if (addr_bad(redirect_target, LIMIT))
            state_d = FS_FAULT;
        end else if (!stall) begin
          // no silent wrap: the last word is delivered, then we fault
          if (addr_bad(pc_q, LIMIT) || addr_bad(pc_plus4, LIMIT))
            state_d = FS_FAULT;
        end
      end
      FS_FAULT: state_d = FS_FAULT;
      default:  state_d = FS_FAULT;
    endcase
  end

  always_comb begin
    load          = 1'b0;
    flush         = 1'b0;
    pc_d          = pc_q;
    fetch_count_d = fetch_count_q;
    unique case (1'b1)
      run_redir: begin
        flush = 1'b1;
        pc_d  = redirect_target;
      end
      run_fetch: begin
        load          = 1'b1;
        pc_d          = pc_plus4;
        fetch_count_d = fetch_count_q + 32'd1;
      end
      in_fault: flush = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q          <= RESET_PC;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  if_id_pipe_reg u_if_id (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .load_i     (load),
    .flush_i    (flush),
    .pc_i       (pc_q),
    .instr_i    (imem_instr),
    .valid_o    (if_id_valid),
    .pc_o       (if_id_pc),
    .pc_plus4_o (if_id_pc_plus4),
    .instr_o    (if_id_instr)
  );

  assign imem_addr   = pc_q;
  assign fetch_fault = in_fault;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: a behavioural model
// pushes expected outputs per cycle, popped and compared after the edge.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int          W   = 256;
  localparam logic [31:0] LIM = 32'h0000_0400;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic [31:0] imem_addr, imem_instr;
  logic        if_id_valid, fetch_fault;
  logic [31:0] if_id_pc, if_id_pc_plus4, if_id_instr, fetch_count;

  instruction_fetch_unit #(
    .RESET_PC   (32'h0),
    .IMEM_WORDS (W)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .imem_addr       (imem_addr),
    .imem_instr      (imem_instr),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .if_id_valid     (if_id_valid),
    .if_id_pc        (if_id_pc),
    .if_id_pc_plus4  (if_id_pc_plus4),
    .if_id_instr     (if_id_instr),
    .fetch_fault     (fetch_fault),
    .fetch_count     (fetch_count)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [W];
  assign imem_instr = (imem_addr < LIM) ? mem[imem_addr[9:2]]
                                        : 32'hDEAD_BEEF;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ipc;
    logic [31:0] ipc4;
    logic [31:0] instr;
    logic [31:0] cnt;
    logic        v;
    logic        flt;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  logic [31:0] m_pc, m_ipc, m_ipc4, m_instr, m_cnt;
  logic        m_v;
  int          m_st;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= LIM);
  endfunction

  task automatic step(input logic rst, input logic st,
                      input logic rv, input logic [31:0] tgt);
    exp_t e;
    @(negedge clk);
    reset_n = rst;
    stall = st;
    redirect_valid = rv;
    redirect_target = tgt;
    if (!rst) begin
      m_pc = 32'h0; m_st = 0; m_v = 1'b0;
      m_ipc = '0; m_ipc4 = '0; m_instr = NOP; m_cnt = '0;
    end else begin
      case (m_st)
        0: m_st = 1;
        1: begin
          if (rv) begin
            m_v = 1'b0; m_instr = NOP; m_pc = tgt;
            if (bad(tgt)) m_st = 2;
          end else if (!st) begin
            if (bad(m_pc)) m_st = 2;
            else begin
              m_v = 1'b1; m_ipc = m_pc; m_ipc4 = m_pc + 32'd4;
              m_instr = mem[m_pc[9:2]];
              m_cnt = m_cnt + 32'd1;
              m_pc = m_pc + 32'd4;
              if (m_pc >= LIM) m_st = 2;
            end
          end
        end
        default: begin m_v = 1'b0; m_instr = NOP; end
      endcase
    end
    e = '{pc: m_pc, ipc: m_ipc, ipc4: m_ipc4, instr: m_instr,
          cnt: m_cnt, v: m_v, flt: (m_st == 2)};
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("imem_addr", imem_addr, e.pc);
    chk("valid", 32'(if_id_valid), 32'(e.v));
    chk("if_id_pc", if_id_pc, e.ipc);
    chk("if_id_pc4", if_id_pc_plus4, e.ipc4);
    chk("if_id_instr", if_id_instr, e.instr);
    chk("fault", 32'(fetch_fault), 32'(e.flt));
    chk("count", fetch_count, e.cnt);
  endtask

  initial begin
    for (int i = 0; i < W; i++)
      mem[i] = (32'(i) * 32'h0101_0001) ^ 32'h1357_9BD3;

    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h40);

    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("boot_valid", 32'(if_id_valid), 32'd0);
    chk("boot_addr", imem_addr, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("first_pc", if_id_pc, 32'h0);
    chk("first_instr", if_id_instr, mem[0]);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("second_pc", if_id_pc, 32'h4);

    repeat (3) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      chk("stall_ipc", if_id_pc, 32'h4);
      chk("stall_addr", imem_addr, 32'h8);
      chk("stall_cnt", fetch_count, 32'd2);
    end
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("unstall_pc", if_id_pc, 32'h8);

    step(1'b1, 1'b1, 1'b1, 32'h40);
    chk("redir_valid", 32'(if_id_valid), 32'd0);
    chk("redir_nop", if_id_instr, NOP);
    chk("redir_addr", imem_addr, 32'h40);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("redir_ipc", if_id_pc, 32'h40);

    repeat (20)
      step(1'b1, 1'($urandom_range(0, 3) == 0), 1'b0, 32'h0);

    step(1'b1, 1'b1, 1'b0, 32'h0);
    force dut.fetch_count_q = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    step(1'b1, 1'b1, 1'b0, 32'h0);
    release dut.fetch_count_q;
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("cnt_wrap", fetch_count, 32'h0);

    step(1'b1, 1'b0, 1'b1, 32'h3F0);
    repeat (4) step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("last_ipc", if_id_pc, 32'h3FC);
    chk("last_valid", 32'(if_id_valid), 32'd1);
    chk("end_fault", 32'(fetch_fault), 32'd1);
    chk("end_addr", imem_addr, 32'h400);
    repeat (4)
      step(1'b1, 1'($urandom_range(0, 1)), 1'b1, 32'h20);
    chk("end_hold", imem_addr, 32'h400);

    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 32'h42);
    chk("mis_fault", 32'(fetch_fault), 32'd1);
    chk("mis_addr", imem_addr, 32'h42);
    repeat (12)
      step(1'b1, 1'($urandom_range(0, 1)), 1'b1, 32'h100);
    chk("mis_hold_v", 32'(if_id_valid), 32'd0);
    chk("mis_hold_f", 32'(fetch_fault), 32'd1);
    step(1'b0, 1'b1, 1'b1, 32'h80);
    chk("rst_clear_f", 32'(fetch_fault), 32'd0);
    chk("rst_pc", imem_addr, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("rst_refetch", if_id_instr, mem[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded on reset.
REQ-002 SHALL have parameter IMEM_WORDS, default 256, meaning the instruction memory depth in 32-bit words; the legal byte range is 0 .. IMEM_WORDS*4-1.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port imem_addr, output, 32 bits: byte address to the instruction memory; always equals the current pc.
REQ-006 SHALL have port imem_instr, input, 32 bits: instruction word returned combinationally for imem_addr in the same cycle.
REQ-007 SHALL have port stall, input, 1 bit: decode stage cannot accept; hold pc and the IF/ID outputs.
REQ-008 SHALL have port redirect_valid, input, 1 bit: branch/jump taken; load redirect_target into pc.
REQ-009 SHALL have port redirect_target, input, 32 bits: new pc byte address.
REQ-010 SHALL have port if_id_valid, output, 1 bit: IF/ID register holds a real instruction.
REQ-011 SHALL have port if_id_pc, output, 32 bits: pc of the instruction in IF/ID.
REQ-012 SHALL have port if_id_pc_plus4, output, 32 bits: if_id_pc + 4, modulo 2^32.
REQ-013 SHALL have port if_id_instr, output, 32 bits: latched instruction; NOP 32'h0000_0013 when not valid.
REQ-014 SHALL have port fetch_fault, output, 1 bit: sticky misaligned or out-of-range fetch fault.
REQ-015 SHALL have port fetch_count, output, 32 bits: count of instructions delivered with if_id_valid=1; wraps.

Function
REQ-016 SHALL implement FSM states BOOT, RUN, FAULT.
REQ-017 In BOOT, SHALL perform no fetch and hold if_id_valid at 0 for exactly one cycle, then enter RUN.
REQ-018 In RUN with no redirect and no stall, SHALL load IF/ID with {pc, pc+4, imem_instr} and set if_id_valid=1 on the edge, then set pc <= pc+4 and increment fetch_count by 1; fetch latency is one cycle, with one instruction per cycle.
REQ-019 In RUN with stall=1 and no redirect, SHALL hold pc, all IF/ID outputs, and fetch_count unchanged.
REQ-020 When redirect_valid=1 in RUN, SHALL take priority over stall: set pc <= redirect_target, set if_id_valid <= 0, set if_id_instr <= NOP, and leave fetch_count unchanged.
REQ-021 When redirect_target[1:0] != 0 or redirect_target >= IMEM_WORDS*4 is accepted, SHALL enter FAULT instead of fetching.
REQ-022 When sequential pc+4 reaches IMEM_WORDS*4 and is accepted, SHALL enter FAULT; there is no silent address wrap.
REQ-023 In FAULT, SHALL assert fetch_fault=1, hold if_id_valid=0 and if_id_instr=NOP, hold pc at the faulting address, and ignore stall and redirect; only reset exits FAULT.
REQ-024 fetch_count SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-025 imem_addr SHALL be driven from the pc register only, never combinationally from redirect_target.

Reset
REQ-026 When reset_n=0 at a rising edge, SHALL set pc=RESET_PC, state=BOOT, if_id_valid=0, if_id_pc=0, if_id_pc_plus4=0, if_id_instr=NOP, fetch_fault=0, and fetch_count=0.
REQ-027 Reset mid-operation, including while in FAULT or during a stall or redirect, SHALL override all other inputs in that cycle.

Structure
REQ-028 A shared package rv32_pkg SHALL hold the NOP constant 32'h0000_0013, the fetch FSM state enum, and the default RESET_PC.
REQ-029 One sub-module, if_id_pipe_reg, SHALL hold the IF/ID register with load, hold, and flush controls; all pc and FSM logic stays in instruction_fetch_unit.

Verification
REQ-030 Reset sequence: after reset release, cycle 1 SHALL show imem_addr=0 and if_id_valid=0; cycle 2 SHALL show if_id_valid=1, if_id_pc=0, and if_id_instr=mem[0]; cycle 3 SHALL show if_id_pc=4.
REQ-031 Stall at pc=8 for 3 cycles SHALL hold if_id_pc=4, hold imem_addr=8, and hold fetch_count; on release, if_id_pc=8 SHALL follow on the next edge.
REQ-032 Redirect to 32'h40 with stall=1 in the same cycle SHALL give next-cycle if_id_valid=0, if_id_instr=NOP, and imem_addr=32'h40; the following cycle SHALL give if_id_pc=32'h40.
REQ-033 Redirect to 32'h42 SHALL set fetch_fault=1 and if_id_valid=0 held for 10+ cycles regardless of redirects; reset_n=0 SHALL clear it, returning to pc=RESET_PC.
REQ-034 Sequential run to pc=32'h3FC with IMEM_WORDS=256 SHALL deliver the instruction at 32'h3FC, then enter FAULT with imem_addr=32'h400.
REQ-035 A preloaded fetch_count of 32'hFFFF_FFFF followed by one delivered instruction SHALL read fetch_count=0.
